// File: rtl/oser10_link_ctrl.sv
// Startup sequencer and word scheduler for one 10:1 serializer lane.
// Define OSER10_PRBS_EN to build the optional PRBS7 test source.
module oser10_link_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned TRAIN_CYCLES  = 1024,
  parameter logic [9:0]  TRAIN_PATTERN = 10'b1101010100,
  parameter logic [9:0]  IDLE_PATTERN  = 10'b1101010100,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_par,
  input  logic             arst,
  input  logic             pll_lock,
  input  logic             enable,
  input  logic [9:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             prbs_mode,
  output logic             oser_rst,
  output logic [9:0]       oser_d,
  output logic             link_up,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam int unsigned CYC_MAX =
    (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
  localparam int unsigned CYC_W = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TRN_LAST = CYC_W'(TRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_TRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t st, st_n;
  logic lock_q, lock_s;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic [9:0] mem [2];
  logic rp, rp_n, wp, wp_n;
  logic [1:0] cnt, cnt_n;
  logic run_hold, push, pop, flush;
  logic [9:0] d_n;
  logic [CNT_W-1:0] uf_n;
  logic ready_n;
  logic prbs_on;
  logic [9:0] prbs_word;

  assign state = st;

  always_ff @(posedge clk_par or posedge arst) begin
    if (arst) begin
      lock_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_q <= pll_lock;
      lock_s <= lock_q;
    end
  end

  // next state; lock loss overrides everything, enable drop overrides timers
  always_comb begin
    st_n = st;
    unique case (st)
      S_RESET: if (lock_s && cyc == RST_LAST)
                 st_n = enable ? S_TRAIN : S_IDLE;
      S_IDLE:  if (enable) st_n = S_TRAIN;
      S_TRAIN: if (!enable) st_n = S_IDLE;
               else if (cyc == TRN_LAST) st_n = S_RUN;
      S_RUN:   if (!enable) st_n = S_IDLE;
      default: st_n = S_RESET;
    endcase
    if (!lock_s) st_n = S_RESET;
  end

  always_comb begin
    cyc_n = '0;
    if (st_n == st && lock_s &&
        (st == S_RESET || st == S_TRAIN))
      cyc_n = cyc + CYC_W'(1);
  end

  always_comb begin
    run_hold = (st == S_RUN) && (st_n == S_RUN);
    flush    = !run_hold || prbs_on;
    pop      = run_hold && !prbs_on && (cnt != 2'd0);
    push     = s_valid && s_ready && !flush;
    cnt_n    = '0;
    rp_n     = 1'b0;
    wp_n     = 1'b0;
    if (!flush) begin
      cnt_n = cnt + 2'(push) - 2'(pop);
      rp_n  = rp ^ pop;
      wp_n  = wp ^ push;
    end
    ready_n = (st_n == S_RUN) && !prbs_on && (cnt_n < 2'd2);
  end

  always_comb begin
    d_n  = IDLE_PATTERN;
    uf_n = underflow_cnt;
    if (st_n == S_TRAIN) begin
      d_n = TRAIN_PATTERN;
    end else if (run_hold) begin
      if (prbs_on)
        d_n = prbs_word;
      else if (pop)
        d_n = mem[rp];
      else if (underflow_cnt != '1)
        uf_n = underflow_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_par or posedge arst) begin
    if (arst) begin
      st            <= S_RESET;
      cyc           <= '0;
      cnt           <= '0;
      rp            <= 1'b0;
      wp            <= 1'b0;
      mem[0]        <= '0;
      mem[1]        <= '0;
      oser_d        <= IDLE_PATTERN;
      oser_rst      <= 1'b1;
      s_ready       <= 1'b0;
      link_up       <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      st            <= st_n;
      cyc           <= cyc_n;
      cnt           <= cnt_n;
      rp            <= rp_n;
      wp            <= wp_n;
      if (push) mem[wp] <= s_data;
      oser_d        <= d_n;
      oser_rst      <= (st_n == S_RESET);
      s_ready       <= ready_n;
      link_up       <= (st_n == S_RUN);
      underflow_cnt <= uf_n;
    end
  end

`ifdef OSER10_PRBS_EN
  logic [6:0] lfsr, lfsr_n;

  // x^7+x^6+1, ten steps per word, word bit 0 is the oldest bit
  function automatic logic [16:0] prbs_step(input logic [6:0] s);
    logic [6:0] r;
    logic [9:0] w;
    r = s;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      w[i] = r[6] ^ r[5];
      r    = {r[5:0], w[i]};
    end
    return {r, w};
  endfunction

  assign {lfsr_n, prbs_word} = prbs_step(lfsr);
  assign prbs_on = prbs_mode;

  always_ff @(posedge clk_par or posedge arst) begin
    if (arst)
      lfsr <= 7'h7F;
    else if (st != S_RUN && st_n == S_RUN)
      lfsr <= 7'h7F;
    else if (run_hold && prbs_on)
      lfsr <= lfsr_n;
  end
`else
  logic unused_prbs;
  assign prbs_on     = 1'b0;
  assign prbs_word   = IDLE_PATTERN;
  assign unused_prbs = prbs_mode;
`endif

endmodule

// File: tb/tb_oser10_link_ctrl.sv
// Scoreboard bench for oser10_link_ctrl: startup, streaming,
// underflow, lock loss, enable drop and counter saturation.
module tb_oser10_link_ctrl;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] TRN  = 10'b1101010100;

  logic clk_par = 1'b0;
  logic arst = 1'b1;
  logic pll_lock = 1'b0;
  logic enable = 1'b0;
  logic [9:0] s_data = '0;
  logic s_valid = 1'b0;
  logic prbs_mode = 1'b0;
  logic s_ready, oser_rst, link_up;
  logic [9:0] oser_d;
  logic [1:0] state;
  logic [15:0] underflow_cnt;

  logic sat_lock = 1'b1;
  logic sat_en = 1'b1;
  logic sat_valid = 1'b0;
  logic sat_prbs = 1'b0;
  logic [9:0] sat_data = '0;
  logic sat_ready, sat_rst, sat_link;
  logic [9:0] sat_d;
  logic [1:0] sat_state;
  logic [2:0] sat_cnt;

  int checks = 0;
  int failures = 0;
  logic [9:0] q[$];

  oser10_link_ctrl dut (
    .clk_par(clk_par), .arst(arst),
    .pll_lock(pll_lock), .enable(enable),
    .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .prbs_mode(prbs_mode),
    .oser_rst(oser_rst), .oser_d(oser_d),
    .link_up(link_up), .state(state),
    .underflow_cnt(underflow_cnt)
  );

  oser10_link_ctrl #(
    .RST_CYCLES(2), .TRAIN_CYCLES(4), .CNT_W(3)
  ) u_sat (
    .clk_par(clk_par), .arst(arst),
    .pll_lock(sat_lock), .enable(sat_en),
    .s_data(sat_data), .s_valid(sat_valid),
    .s_ready(sat_ready), .prbs_mode(sat_prbs),
    .oser_rst(sat_rst), .oser_d(sat_d),
    .link_up(sat_link), .state(sat_state),
    .underflow_cnt(sat_cnt)
  );

  always #5 clk_par = ~clk_par;

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic count_rst(output int n);
    n = 0;
    while (oser_rst === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_par);
    end
  endtask

  task automatic count_train(output int n, output int bad);
    n = 0;
    bad = 0;
    while (state === 2'd2 && n < 2000) begin
      n++;
      if (oser_d !== TRN) bad++;
      @(negedge clk_par);
    end
  endtask

  // one clock of stimulus; scoreboard push on accept, pop on output
  task automatic sb_cycle(input logic v, input logic [9:0] w,
                          output logic acc, output logic he,
                          output logic [9:0] e);
    logic hs, was_run;
    s_valid = v;
    s_data  = w;
    hs      = v && s_ready;
    was_run = (state === 2'd3);
    @(negedge clk_par);
    acc = 1'b0;
    he  = 1'b0;
    e   = IDLE;
    if (was_run) begin
      he = 1'b1;
      if (state === 2'd3) begin
        if (q.size() > 0) e = q.pop_front();
      end else begin
        q.delete();
      end
    end
    if (hs && state === 2'd3) begin
      q.push_back(w);
      acc = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    arst = 1'b1;
    pll_lock = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_par);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if (oser_rst !== 1'b1 || s_ready !== 1'b0 || link_up !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b%b%b exp=100",
               oser_rst, s_ready, link_up);
    end
    checks++;
    if (oser_d !== IDLE || underflow_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=%h/0",
               oser_d, underflow_cnt, IDLE);
    end
    arst = 1'b0;
    count_rst(n);
    checks++;
    if (n != 18) begin
      failures++;
      $display("FAIL rst_cycles got=%0d exp=18", n);
    end
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL rst_to_train got=%0d exp=2", state);
    end
  endtask

  task automatic test_train;
    int n, bad;
    count_train(n, bad);
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL train_len got=%0d exp=1024", n);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL train_word got=%0d bad exp=0", bad);
    end
    checks++;
    if (state !== 2'd3 || link_up !== 1'b1) begin
      failures++;
      $display("FAIL run_entry got=%0d/%b exp=3/1", state, link_up);
    end
    checks++;
    if (oser_d !== IDLE || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL run_entry_out got=%h/%b exp=%h/1",
               oser_d, s_ready, IDLE);
    end
  endtask

  task automatic test_stream;
    int idx, cyc;
    logic acc, he;
    logic [9:0] e;
    logic [15:0] uf0;
    idx = 1;
    cyc = 0;
    uf0 = '0;
    while (idx <= 10 && cyc < 50) begin
      sb_cycle(1'b1, 10'(idx), acc, he, e);
      if (he) begin
        checks++;
        if (oser_d !== e) begin
          failures++;
          $display("FAIL stream_word got=%h exp=%h", oser_d, e);
        end
      end
      if (acc) begin
        if (idx == 1) uf0 = underflow_cnt;
        idx++;
      end
      cyc++;
    end
    while (q.size() > 0 && cyc < 60) begin
      sb_cycle(1'b0, 10'h0, acc, he, e);
      checks++;
      if (oser_d !== e) begin
        failures++;
        $display("FAIL stream_drain got=%h exp=%h", oser_d, e);
      end
      cyc++;
    end
    checks++;
    if (idx != 11) begin
      failures++;
      $display("FAIL stream_accept got=%0d exp=10", idx - 1);
    end
    checks++;
    if (underflow_cnt !== uf0) begin
      failures++;
      $display("FAIL stream_uf got=%0d exp=%0d", underflow_cnt, uf0);
    end
  endtask

  task automatic test_underflow;
    logic acc, he;
    logic [9:0] e;
    logic [15:0] uf0;
    uf0 = underflow_cnt;
    for (int i = 0; i < 5; i++) begin
      sb_cycle(1'b0, 10'h0, acc, he, e);
      checks++;
      if (oser_d !== IDLE) begin
        failures++;
        $display("FAIL uf_word got=%h exp=%h", oser_d, IDLE);
      end
    end
    checks++;
    if (underflow_cnt !== 16'(uf0 + 16'd5)) begin
      failures++;
      $display("FAIL uf_count got=%0d exp=%0d",
               underflow_cnt, 16'(uf0 + 16'd5));
    end
  endtask

  task automatic test_lock_loss;
    int n, bad;
    logic acc, he;
    logic [9:0] e;
    n = 0;
    pll_lock = 1'b0;
    while (state !== 2'd0 && n < 10) begin
      sb_cycle(1'b1, 10'h100 + 10'(n), acc, he, e);
      checks++;
      if (oser_d !== e) begin
        failures++;
        $display("FAIL lock_loss_word got=%h exp=%h", oser_d, e);
      end
      n++;
    end
    s_valid = 1'b0;
    checks++;
    if (n > 3 || state !== 2'd0) begin
      failures++;
      $display("FAIL lock_loss_lat got=%0d exp<=3", n);
    end
    checks++;
    if (oser_rst !== 1'b1 || s_ready !== 1'b0 || link_up !== 1'b0) begin
      failures++;
      $display("FAIL lock_loss_ctl got=%b%b%b exp=100",
               oser_rst, s_ready, link_up);
    end
    pll_lock = 1'b1;
    count_rst(n);
    checks++;
    if (n != 18 || state !== 2'd2) begin
      failures++;
      $display("FAIL relock_rst got=%0d/%0d exp=18/2", n, state);
    end
    count_train(n, bad);
    checks++;
    if (n != 1024 || bad != 0) begin
      failures++;
      $display("FAIL relock_train got=%0d/%0d exp=1024/0", n, bad);
    end
    for (int i = 0; i < 3; i++) begin
      sb_cycle(1'b0, 10'h0, acc, he, e);
      checks++;
      if (oser_d !== IDLE || state !== 2'd3) begin
        failures++;
        $display("FAIL relock_stale got=%h/%0d exp=%h/3",
                 oser_d, state, IDLE);
      end
    end
  endtask

  task automatic test_enable_drop;
    int n, bad;
    enable = 1'b0;
    @(negedge clk_par);
    checks++;
    if (state !== 2'd1 || s_ready !== 1'b0 || link_up !== 1'b0) begin
      failures++;
      $display("FAIL run_to_idle got=%0d/%b/%b exp=1/0/0",
               state, s_ready, link_up);
    end
    enable = 1'b1;
    @(negedge clk_par);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL idle_to_train got=%0d exp=2", state);
    end
    repeat (100) @(negedge clk_par);
    enable = 1'b0;
    @(negedge clk_par);
    checks++;
    if (state !== 2'd1 || oser_rst !== 1'b0 || oser_d !== IDLE) begin
      failures++;
      $display("FAIL train_to_idle got=%0d/%b/%h exp=1/0/%h",
               state, oser_rst, oser_d, IDLE);
    end
    repeat (9) @(negedge clk_par);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL idle_hold got=%0d exp=1", state);
    end
    enable = 1'b1;
    @(negedge clk_par);
    count_train(n, bad);
    checks++;
    if (n != 1024 || bad != 0 || state !== 2'd3) begin
      failures++;
      $display("FAIL retrain got=%0d/%0d/%0d exp=1024/0/3",
               n, bad, state);
    end
  endtask

  task automatic test_lock_enable_drop;
    int n;
    n = 0;
    pll_lock = 1'b0;
    enable = 1'b0;
    while (state !== 2'd0 && n < 10) begin
      @(negedge clk_par);
      n++;
    end
    checks++;
    if (n > 3 || oser_rst !== 1'b1) begin
      failures++;
      $display("FAIL both_drop got=%0d/%b exp<=3/1", n, oser_rst);
    end
    pll_lock = 1'b1;
    count_rst(n);
    checks++;
    if (n != 18 || state !== 2'd1) begin
      failures++;
      $display("FAIL rst_to_idle got=%0d/%0d exp=18/1", n, state);
    end
  endtask

  task automatic test_saturate;
    checks++;
    if (sat_cnt !== 3'd7) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=7", sat_cnt);
    end
    repeat (20) @(negedge clk_par);
    checks++;
    if (sat_cnt !== 3'd7 || sat_state !== 2'd3) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%0d exp=7/3", sat_cnt, sat_state);
    end
    checks++;
    if (sat_link !== 1'b1 || sat_rst !== 1'b0 ||
        sat_ready !== 1'b1 || sat_d !== IDLE) begin
      failures++;
      $display("FAIL sat_out got=%b%b%b/%h exp=101/%h",
               sat_link, sat_rst, sat_ready, sat_d, IDLE);
    end
  endtask

`ifdef OSER10_PRBS_EN
  task automatic test_prbs;
    int n, bad;
    logic h[$];
    logic [9:0] w;
    logic [15:0] uf0;
    for (int i = 0; i < 7; i++) h.push_back(1'b1);
    uf0 = underflow_cnt;
    prbs_mode = 1'b1;
    enable = 1'b1;
    @(negedge clk_par);
    count_train(n, bad);
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < 10; b++) begin
        w[b] = h[h.size() - 7] ^ h[h.size() - 6];
        h.push_back(w[b]);
      end
      @(negedge clk_par);
      checks++;
      if (oser_d !== w || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL prbs_word got=%h/%b exp=%h/0", oser_d, s_ready, w);
      end
    end
    checks++;
    if (underflow_cnt !== uf0) begin
      failures++;
      $display("FAIL prbs_uf got=%0d exp=%0d", underflow_cnt, uf0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_train();
    test_stream();
    test_underflow();
    test_lock_loss();
    test_enable_drop();
    test_lock_enable_drop();
    test_saturate();
`ifdef OSER10_PRBS_EN
    test_prbs();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
